// File: rtl/agc_pkg.sv
// Shared types and helpers for the AGC front-end DC remover.
package agc_pkg;

    // Per-channel loop phase: fast acquisition, then slow tracking.
    typedef enum logic {
        PH_ACQ = 1'b0,
        PH_TRK = 1'b1
    } phase_t;

    // Working width of the generic clamp helper; covers any 3*DW+1 sum for DW <= 42.
    localparam int unsigned SAT_W = 128;

    // Channel-index width, at least one bit even for a single channel.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Clamp a signed value to the signed range of a w-bit word.
    function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] x,
                                                    input int unsigned w);
        logic signed [SAT_W-1:0] lim;
        lim = SAT_W'(1) << (w - 1);
        if (x >= lim)
            return lim - SAT_W'(1);
        else if (x < -lim)
            return -lim;
        else
            return x;
    endfunction

endpackage

// File: rtl/dc_chan_ctrl.sv
// Per-channel phase controller: ACQUIRE for SETTLE_LEN accepted samples, then TRACK.
module dc_chan_ctrl
    import agc_pkg::*;
#(
    parameter int unsigned SETTLE_LEN = 256
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ce,
    input  logic hit,       // accepted, unfrozen sample for this channel
    input  logic restart,
    output logic settled,
    output logic sel_trk
);

    localparam int unsigned    CW   = (SETTLE_LEN > 1) ? $clog2(SETTLE_LEN) : 1;
    localparam logic [CW-1:0]  LAST = CW'(SETTLE_LEN - 1);

    phase_t        state;
    phase_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // Phase and sample-count registers, held while ce is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= PH_ACQ;
            cnt   <= '0;
        end else if (ce) begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next phase: count accepts in ACQUIRE, switch on the last one; TRACK is sticky.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (restart) begin
            state_next = PH_ACQ;
            cnt_next   = '0;
        end else begin
            case (state)
                PH_ACQ: begin
                    if (hit) begin
                        if (cnt == LAST)
                            state_next = PH_TRK;
                        else
                            cnt_next = cnt + 1'b1;
                    end
                end
                PH_TRK: begin
                    state_next = PH_TRK;
                end
                default: begin
                    state_next = PH_ACQ;
                end
            endcase
        end
    end

    assign settled = (state == PH_TRK);
    assign sel_trk = (state == PH_TRK);

endmodule

// File: rtl/dc_remove_mc.sv
// Time-multiplexed multi-channel DC remover: one integrator per channel, one shared datapath.
module dc_remove_mc
    import agc_pkg::*;
#(
    parameter int unsigned  DW         = 16,
    parameter int unsigned  CH         = 4,
    parameter int unsigned  SHIFT_ACQ  = 12,
    parameter int unsigned  SHIFT_TRK  = 8,
    parameter int unsigned  SETTLE_LEN = 256,
    localparam int unsigned CHW        = ch_width(CH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ce,
    input  logic                 din_valid,
    input  logic [CHW-1:0]       din_ch,
    input  logic signed [DW-1:0] din,
    input  logic                 freeze,
    input  logic                 restart,
    output logic                 dout_valid,
    output logic [CHW-1:0]       dout_ch,
    output logic signed [DW-1:0] dout,
    output logic signed [DW-1:0] mean,
    output logic [CH-1:0]        settled
);

    localparam int unsigned AW = 2 * DW;      // accumulator width
    localparam int unsigned SW = 3 * DW + 1;  // holds acc + (e <<< shift) for any shift < 2*DW

    logic signed [AW-1:0] acc [CH];
    logic [CH-1:0]        sel_trk;

    logic                 in_range;
    logic                 accept;
    logic                 upd;
    logic [CHW-1:0]       ch_idx;
    logic signed [AW-1:0] acc_sel;
    logic signed [DW-1:0] m;
    logic signed [DW:0]   diff;
    logic signed [DW-1:0] e;
    int unsigned          shift_amt;
    logic signed [SW-1:0] incr;
    logic signed [SW-1:0] sum;
    logic signed [AW-1:0] acc_next;

    // Shared datapath: read selected integrator, form clamped error and saturated update.
    always_comb begin
        in_range  = (32'(din_ch) < CH);
        accept    = din_valid & in_range;
        upd       = accept & ~freeze & ~restart;
        ch_idx    = in_range ? din_ch : '0;
        acc_sel   = acc[ch_idx];
        m         = acc_sel[AW-1:DW];
        diff      = (DW+1)'(din) - (DW+1)'(m);
        e         = DW'(sat(SAT_W'(diff), DW));
        shift_amt = sel_trk[ch_idx] ? SHIFT_TRK : SHIFT_ACQ;
        incr      = SW'(e) <<< shift_amt;
        sum       = SW'(acc_sel) + incr;
        acc_next  = AW'(sat(SAT_W'(sum), AW));
    end

    // Integrator bank: restart clears all channels and wins over freeze.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < CH; i++)
                acc[i] <= '0;
        end else if (ce) begin
            if (restart) begin
                for (int unsigned i = 0; i < CH; i++)
                    acc[i] <= '0;
            end else if (upd) begin
                acc[ch_idx] <= acc_next;
            end
        end
    end

    // Output register: one-cycle strobe per accepted sample, data holds otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_valid <= 1'b0;
            dout_ch    <= '0;
            dout       <= '0;
            mean       <= '0;
        end else if (ce) begin
            dout_valid <= accept;
            if (accept) begin
                dout_ch <= din_ch;
                dout    <= e;
                mean    <= m;
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        dc_chan_ctrl #(
            .SETTLE_LEN(SETTLE_LEN)
        ) u_ctrl (
            .clk     (clk),
            .reset_n (reset_n),
            .ce      (ce),
            .hit     (upd && (ch_idx == CHW'(g))),
            .restart (restart),
            .settled (settled[g]),
            .sel_trk (sel_trk[g])
        );
    end

endmodule

// File: tb/tb_dc_remove_mc.sv
// Directed self-checking bench for dc_remove_mc (4-channel and 3-channel builds).
module tb_dc_remove_mc;

    logic clk = 1'b0;
    logic reset_n;
    logic ce;
    logic freeze;
    logic restart;

    logic               a_din_valid;
    logic [1:0]         a_din_ch;
    logic signed [15:0] a_din;
    logic               a_dout_valid;
    logic [1:0]         a_dout_ch;
    logic signed [15:0] a_dout;
    logic signed [15:0] a_mean;
    logic [3:0]         a_settled;

    logic               b_din_valid;
    logic [1:0]         b_din_ch;
    logic signed [15:0] b_din;
    logic               b_dout_valid;
    logic [1:0]         b_dout_ch;
    logic signed [15:0] b_dout;
    logic signed [15:0] b_mean;
    logic [2:0]         b_settled;

    int total = 0;
    int bad   = 0;

    longint macc [4];
    int     mcnt [4];
    bit     mtrk [4];
    int     seq  [100];

    always #5 clk = ~clk;

    dc_remove_mc #(
        .DW(16), .CH(4), .SHIFT_ACQ(12), .SHIFT_TRK(8), .SETTLE_LEN(256)
    ) u_dut_a (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .din_valid(a_din_valid), .din_ch(a_din_ch), .din(a_din),
        .freeze(freeze), .restart(restart),
        .dout_valid(a_dout_valid), .dout_ch(a_dout_ch), .dout(a_dout),
        .mean(a_mean), .settled(a_settled)
    );

    dc_remove_mc #(
        .DW(16), .CH(3), .SHIFT_ACQ(12), .SHIFT_TRK(8), .SETTLE_LEN(256)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .din_valid(b_din_valid), .din_ch(b_din_ch), .din(b_din),
        .freeze(freeze), .restart(restart),
        .dout_valid(b_dout_valid), .dout_ch(b_dout_ch), .dout(b_dout),
        .mean(b_mean), .settled(b_settled)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic mclear();
        for (int i = 0; i < 4; i++) begin
            macc[i] = 0;
            mcnt[i] = 0;
            mtrk[i] = 1'b0;
        end
    endtask

    function automatic logic [3:0] exp_settled();
        logic [3:0] s;
        for (int i = 0; i < 4; i++)
            s[i] = mtrk[i];
        return s;
    endfunction

    // Reference integrator in plain integer arithmetic (gain as multiply, explicit clamps).
    task automatic model(input int ch, input int d, input bit frz, input bit rs,
                         output int ed, output int em);
        longint a;
        longint df;
        a  = macc[ch];
        em = int'(a >>> 16);
        df = longint'(d) - longint'(em);
        if (df > 32767)  df = 32767;
        if (df < -32768) df = -32768;
        ed = int'(df);
        if (rs) begin
            mclear();
        end else if (!frz) begin
            a = a + df * (mtrk[ch] ? 256 : 4096);
            if (a > 64'sd2147483647)  a = 64'sd2147483647;
            if (a < -64'sd2147483648) a = -64'sd2147483648;
            macc[ch] = a;
            if (!mtrk[ch]) begin
                if (mcnt[ch] == 255) mtrk[ch] = 1'b1;
                else                 mcnt[ch]++;
            end
        end
    endtask

    task automatic send(input int ch, input int d);
        int ed, em;
        a_din_valid = 1'b1;
        a_din_ch    = 2'(ch);
        a_din       = 16'(d);
        model(ch, d, freeze, restart, ed, em);
        @(posedge clk); #1;
        a_din_valid = 1'b0;
        restart     = 1'b0;
        chk("a_valid", a_dout_valid, 1);
        chk("a_dout", a_dout, ed);
        chk("a_mean", a_mean, em);
        chk("a_ch", a_dout_ch, ch);
        chk("a_settled", a_settled, exp_settled());
    endtask

    task automatic b_send(input int ch, input int d, input int edv, input int ed, input int em);
        b_din_valid = 1'b1;
        b_din_ch    = 2'(ch);
        b_din       = 16'(d);
        @(posedge clk); #1;
        b_din_valid = 1'b0;
        chk("b_valid", b_dout_valid, edv);
        chk("b_dout", b_dout, ed);
        chk("b_mean", b_mean, em);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        mclear();
        chk("rst_settled", a_settled, 0);
    endtask

    initial begin
        reset_n = 1'b0; ce = 1'b1; freeze = 1'b0; restart = 1'b0;
        a_din_valid = 1'b0; a_din_ch = '0; a_din = '0;
        b_din_valid = 1'b0; b_din_ch = '0; b_din = '0;
        mclear();

        // reset state
        #12;
        chk("r_valid", a_dout_valid, 0);
        chk("r_dout", a_dout, 0);
        chk("r_mean", a_mean, 0);
        chk("r_ch", a_dout_ch, 0);
        chk("r_settled", a_settled, 0);
        chk("r_b_settled", b_settled, 0);
        @(negedge clk) reset_n = 1'b1;

        // 1: ch0 constant 1000
        send(0, 1000); chk("h1_dout", a_dout, 1000); chk("h1_mean", a_mean, 0);
        seq[0] = 1000;
        send(0, 1000); chk("h2_dout", a_dout, 938); chk("h2_mean", a_mean, 62);
        seq[1] = 938;
        send(0, 1000); chk("h3_dout", a_dout, 879); chk("h3_mean", a_mean, 121);
        seq[2] = 879;
        for (int i = 3; i < 600; i++) begin
            send(0, 1000);
            if (i < 100) seq[i] = int'(a_dout);
            if (i == 254) chk("acq_255", a_settled[0], 0);
            if (i == 255) chk("trk_256", a_settled[0], 1);
        end
        chk("err_600", (a_dout <= 2 && a_dout >= -2), 1);
        chk("others_acq", a_settled[3:1], 0);

        // 2: interleaved channels, no crosstalk
        pulse_restart();
        send(0, 1000); chk("i0_seq", a_dout, seq[0]);
        send(1, -500); chk("i1_dout", a_dout, -500); chk("i1_mean", a_mean, 0);
        send(0, 1000); chk("i0_seq", a_dout, seq[1]);
        send(1, -500); chk("i2_dout", a_dout, -468); chk("i2_mean", a_mean, -32);
        for (int k = 2; k < 100; k++) begin
            send(0, 1000); chk("i0_seq", a_dout, seq[k]);
            send(1, -500);
        end

        // 3: freeze while settled at mean 1000, then freeze during ACQUIRE
        for (int i = 0; i < 1000; i++) send(0, 1000);
        chk("f_settled0", a_settled[0], 1);
        chk("f_settled1", a_settled[1], 0);
        freeze = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(0, 3000); chk("f_dout", a_dout, 2000); chk("f_mean", a_mean, 1000);
        end
        freeze = 1'b0;
        send(0, 1000); chk("uf_dout", a_dout, 0); chk("uf_mean", a_mean, 1000);
        freeze = 1'b1;
        for (int i = 0; i < 300; i++) send(3, 200);
        chk("f_cnt_hold", a_settled[3], 0);
        freeze = 1'b0;
        for (int i = 0; i < 255; i++) send(3, 200);
        chk("f3_255", a_settled[3], 0);
        send(3, 200);
        chk("f3_256", a_settled[3], 1);

        // 4: full-scale mean then opposite full-scale input
        pulse_restart();
        for (int i = 0; i < 1000; i++) send(0, 32767);
        send(0, -32768); chk("s_dout", a_dout, -32768); chk("s_mean", a_mean, 32767);
        send(0, -32768); chk("s_nowrap", (a_mean > 0), 1);

        // 5: restart with same-cycle sample (also overrides freeze)
        for (int i = 0; i < 1000; i++) send(2, 400);
        freeze  = 1'b1;
        restart = 1'b1;
        send(2, 500); chk("rs_dout", a_dout, 100); chk("rs_mean", a_mean, 400);
        freeze = 1'b0;
        send(2, 500); chk("rs2_dout", a_dout, 500); chk("rs2_mean", a_mean, 0);
        chk("rs2_settled", a_settled, 0);

        // 6: ce low holds everything
        send(1, 700);
        ce = 1'b0;
        a_din_valid = 1'b1; a_din_ch = 2'd0; a_din = -16'sd1234;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("ce_valid", a_dout_valid, 1);
            chk("ce_dout", a_dout, 700);
            chk("ce_mean", a_mean, 0);
            chk("ce_ch", a_dout_ch, 1);
        end
        ce = 1'b1;
        a_din_valid = 1'b0;
        @(posedge clk); #1;
        chk("idle_valid", a_dout_valid, 0);
        chk("idle_dout", a_dout, 700);
        send(0, 1000); chk("ce_noint", a_mean, 0);

        // 6: out-of-range channel on the 3-channel build
        b_send(0, 1000, 1, 1000, 0);
        b_send(3, 7777, 0, 1000, 0);
        chk("b_ch", b_dout_ch, 0);
        b_send(0, 1000, 1, 938, 62);

        // 6: asynchronous reset mid-stream
        for (int i = 0; i < 255; i++) send(1, 0);
        send(1, 300);
        chk("pre_settled1", a_settled[1], 1);
        a_din_valid = 1'b1; a_din_ch = 2'd2; a_din = 16'sd5000;
        b_din_valid = 1'b1; b_din_ch = 2'd0; b_din = 16'sd5000;
        #3 reset_n = 1'b0;
        #1;
        chk("ar_valid", a_dout_valid, 0);
        chk("ar_dout", a_dout, 0);
        chk("ar_mean", a_mean, 0);
        chk("ar_ch", a_dout_ch, 0);
        chk("ar_settled", a_settled, 0);
        chk("ar_b_dout", b_dout, 0);
        chk("ar_b_mean", b_mean, 0);
        a_din_valid = 1'b0;
        b_din_valid = 1'b0;
        #2;
        @(negedge clk) reset_n = 1'b1;
        mclear();
        send(2, 5000); chk("post_dout", a_dout, 5000); chk("post_mean", a_mean, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
